// File: rtl/alu_decode_stage.sv
// RV64 integer ALU decode stage: one registered valid/ready slot.
// Ports: in_valid/in_ready/inst in; out_valid/out_ready, decoded bundle, illegal_count out.
module alu_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [63:0] imm,
  output logic        use_imm,
  output logic        illegal,
  output logic [15:0] illegal_count
);

  localparam logic [3:0] AND_C  = 4'b0000;
  localparam logic [3:0] OR_C   = 4'b0001;
  localparam logic [3:0] ADD_C  = 4'b0010;
  localparam logic [3:0] XOR_C  = 4'b0011;
  localparam logic [3:0] SLL_C  = 4'b0100;
  localparam logic [3:0] SRL_C  = 4'b0101;
  localparam logic [3:0] SUB_C  = 4'b0110;
  localparam logic [3:0] SRA_C  = 4'b0111;
  localparam logic [3:0] SLT_C  = 4'b1000;
  localparam logic [3:0] SLTU_C = 4'b1001;
  localparam logic [3:0] ILL_C  = 4'b1111;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        alt;
  logic        accept;

  logic [3:0]  ctl_d;
  logic [63:0] imm_d;
  logic        ui_d;
  logic        ill_d;

  logic        valid_q;
  logic [3:0]  ctl_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [63:0] imm_q;
  logic        ui_q;
  logic        ill_q;
  logic [15:0] cnt_q;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];
  assign alt = inst[30];

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ctl_d = ADD_C;
    imm_d = '0;
    ui_d  = 1'b0;
    ill_d = 1'b1;
    case (opc)
      7'b0110011: begin
        ill_d = !(f7 == 7'h00 ||
                  (f7 == 7'h20 &&
                   (f3 == 3'b000 || f3 == 3'b101)));
        case (f3)
          3'b000:  ctl_d = alt ? SUB_C : ADD_C;
          3'b001:  ctl_d = SLL_C;
          3'b010:  ctl_d = SLT_C;
          3'b011:  ctl_d = SLTU_C;
          3'b100:  ctl_d = XOR_C;
          3'b101:  ctl_d = alt ? SRA_C : SRL_C;
          3'b110:  ctl_d = OR_C;
          default: ctl_d = AND_C;
        endcase
      end
      7'b0010011: begin
        ill_d = 1'b0;
        ui_d  = 1'b1;
        imm_d = {{52{inst[31]}}, inst[31:20]};
        case (f3)
          3'b000: ctl_d = ADD_C;
          3'b010: ctl_d = SLT_C;
          3'b011: ctl_d = SLTU_C;
          3'b100: ctl_d = XOR_C;
          3'b110: ctl_d = OR_C;
          3'b111: ctl_d = AND_C;
          3'b001: begin
            ctl_d = SLL_C;
            imm_d = {58'd0, inst[25:20]};
            ill_d = inst[31:26] != 6'b000000;
          end
          default: begin
            // RV64 shamt is 6 bits; inst[30] picks SRA
            ctl_d = alt ? SRA_C : SRL_C;
            imm_d = {58'd0, inst[25:20]};
            ill_d = !(inst[31:26] == 6'b000000 ||
                      inst[31:26] == 6'b010000);
          end
        endcase
      end
      7'b0000011: begin
        ill_d = 1'b0;
        ui_d  = 1'b1;
        imm_d = {{52{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        ill_d = 1'b0;
        ui_d  = 1'b1;
        imm_d = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        ill_d = f3[2:1] == 2'b01;
        imm_d = {{52{inst[31]}}, inst[7], inst[30:25],
                 inst[11:8], 1'b0};
        case (f3[2:1])
          2'b00:   ctl_d = SUB_C;
          2'b10:   ctl_d = SLT_C;
          default: ctl_d = SLTU_C;
        endcase
      end
      default: ill_d = 1'b1;
    endcase
    // illegal words travel downstream with a neutral payload
    if (ill_d) begin
      ctl_d = ILL_C;
      imm_d = '0;
      ui_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      ui_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        ctl_q   <= ctl_d;
        rs1_q   <= inst[19:15];
        rs2_q   <= inst[24:20];
        rd_q    <= inst[11:7];
        imm_q   <= imm_d;
        ui_q    <= ui_d;
        ill_q   <= ill_d;
        if (ill_d && cnt_q != 16'hFFFF)
          cnt_q <= cnt_q + 16'd1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = valid_q;
  assign alu_control   = ctl_q;
  assign rs1_addr      = rs1_q;
  assign rs2_addr      = rs2_q;
  assign rd_addr       = rd_q;
  assign imm           = imm_q;
  assign use_imm       = ui_q;
  assign illegal       = ill_q;
  assign illegal_count = cnt_q;

endmodule
